// File: rtl/mic_sampler.sv
// SPI reader for the Pmod MIC3 (ADCS7476) microphone ADC.
// Emits a 12-bit unsigned sample with a one-cycle valid strobe once per sample period.
module mic_sampler #(
    parameter int CLK_DIV    = 2,
    parameter int SAMPLE_DIV = 2500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        miso,
    output logic        cs_n,
    output logic        sclk,
    output logic [11:0] sample,
    output logic        sample_valid,
    output logic        frame_err
);

    localparam int TW = $clog2(SAMPLE_DIV);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_DIV - 1);
    localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, START, SHIFT, QUIET, DONE} state_t;

    state_t         state_r, state_s;
    logic [TW-1:0]  timer_r, timer_s;
    logic [DW-1:0]  div_r, div_s;
    logic [3:0]     bit_r, bit_s;
    logic [15:0]    shift_r, shift_s;
    logic           cs_n_r, cs_n_s;
    logic           sclk_r, sclk_s;
    logic [11:0]    sample_r, sample_s;
    logic           valid_r, valid_s;
    logic           err_r, err_s;
    logic           div_done_s;

    // Next-state logic: sample timer, frame sequencer and output capture.
    always_comb begin
        state_s    = state_r;
        div_s      = div_r;
        bit_s      = bit_r;
        shift_s    = shift_r;
        cs_n_s     = cs_n_r;
        sclk_s     = sclk_r;
        sample_s   = sample_r;
        valid_s    = 1'b0;
        err_s      = 1'b0;
        div_done_s = (div_r == DIV_LAST);

        if (!enable) begin
            timer_s = '0;
        end else if (timer_r == TIMER_LAST) begin
            timer_s = '0;
        end else begin
            timer_s = timer_r + 1'b1;
        end

        case (state_r)
            IDLE: begin
                cs_n_s = 1'b1;
                sclk_s = 1'b1;
                if (enable && (timer_r == TIMER_LAST)) begin
                    state_s = START;
                    cs_n_s  = 1'b0;
                    div_s   = '0;
                    bit_s   = 4'd0;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (div_done_s) begin
                    state_s = SHIFT;
                    sclk_s  = 1'b0;
                    div_s   = '0;
                end else begin
                    div_s = div_r + 1'b1;
                end
            end
            SHIFT: begin
                if (div_done_s) begin
                    div_s  = '0;
                    sclk_s = ~sclk_r;
                    // A low sclk about to rise is the capture point for miso.
                    if (!sclk_r) begin
                        shift_s = {shift_r[14:0], miso};
                        if (bit_r == 4'd15) begin
                            state_s = QUIET;
                            bit_s   = 4'd0;
                        end else begin
                            bit_s = bit_r + 4'd1;
                        end
                    end else begin
                        shift_s = shift_r;
                    end
                end else begin
                    div_s = div_r + 1'b1;
                end
            end
            QUIET: begin
                if (div_done_s) begin
                    state_s  = DONE;
                    div_s    = '0;
                    cs_n_s   = 1'b1;
                    sample_s = shift_r[11:0];
                    valid_s  = 1'b1;
                    err_s    = |shift_r[15:12];
                end else begin
                    div_s = div_r + 1'b1;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                cs_n_s  = 1'b1;
                sclk_s  = 1'b1;
            end
        endcase
    end

    // State and output registers; reset forces the bus idle immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= IDLE;
            timer_r  <= '0;
            div_r    <= '0;
            bit_r    <= 4'd0;
            shift_r  <= 16'd0;
            cs_n_r   <= 1'b1;
            sclk_r   <= 1'b1;
            sample_r <= 12'd0;
            valid_r  <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            state_r  <= state_s;
            timer_r  <= timer_s;
            div_r    <= div_s;
            bit_r    <= bit_s;
            shift_r  <= shift_s;
            cs_n_r   <= cs_n_s;
            sclk_r   <= sclk_s;
            sample_r <= sample_s;
            valid_r  <= valid_s;
            err_r    <= err_s;
        end
    end

    assign cs_n         = cs_n_r;
    assign sclk         = sclk_r;
    assign sample       = sample_r;
    assign sample_valid = valid_r;
    assign frame_err    = err_r;

endmodule

// File: tb/tb_mic_sampler.sv
// Directed bench for mic_sampler: default instance plus a CLK_DIV=1, SAMPLE_DIV=40 instance,
// each fed by a small ADCS7476 behavioural model.
module tb_mic_sampler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b0, en_a = 1'b0, miso_a = 1'b0;
    logic        cs_a, sclk_a, val_a, err_a;
    logic [11:0] smp_a;
    logic        rst_b = 1'b0, en_b = 1'b0, miso_b = 1'b0;
    logic        cs_b, sclk_b, val_b, err_b;
    logic [11:0] smp_b;

    logic [15:0] word_a = 16'h0000, word_b = 16'h0000;
    int idx_a = 15, idx_b = 15;
    int n_cmp = 0, n_bad = 0;
    int cyc = 0;
    int last_fall = 0;

    mic_sampler u_a (
        .clk(clk), .reset(rst_a), .enable(en_a), .miso(miso_a),
        .cs_n(cs_a), .sclk(sclk_a), .sample(smp_a),
        .sample_valid(val_a), .frame_err(err_a)
    );

    mic_sampler #(.CLK_DIV(1), .SAMPLE_DIV(40)) u_b (
        .clk(clk), .reset(rst_b), .enable(en_b), .miso(miso_b),
        .cs_n(cs_b), .sclk(sclk_b), .sample(smp_b),
        .sample_valid(val_b), .frame_err(err_b)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // ADC models: restart at cs_n fall, present the next bit after every sclk fall.
    always @(negedge cs_a or negedge sclk_a) begin
        if (sclk_a) begin
            idx_a = 15;
        end else if (!cs_a && idx_a >= 0) begin
            miso_a = word_a[idx_a];
            idx_a  = idx_a - 1;
        end
    end

    always @(negedge cs_b or negedge sclk_b) begin
        if (sclk_b) begin
            idx_b = 15;
        end else if (!cs_b && idx_b >= 0) begin
            miso_b = word_b[idx_b];
            idx_b  = idx_b - 1;
        end
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Count negedges until cs_n is seen low; -1 when the budget runs out.
    task automatic wait_fall(input int inst, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (((inst == 0) ? cs_a : cs_b) == 1'b0) begin
                n = i;
                break;
            end
        end
    endtask

    // Follow one frame from cs_n fall; act 1 drops enable (inst a), act 2 pulses reset (inst b).
    task automatic run_frame(input int inst, input int act, input int at_rise,
                             output int lat, output int rises, output int per);
        logic prev, s;
        int r1;
        lat = -1; rises = 0; per = -1; r1 = -1;
        prev = (inst == 0) ? sclk_a : sclk_b;
        for (int i = 1; i <= 120; i++) begin
            @(negedge clk);
            s = (inst == 0) ? sclk_a : sclk_b;
            if (s && !prev) begin
                rises++;
                if (rises == 1) r1 = i;
                if (rises == 2) per = i - r1;
                if (rises == at_rise && act == 1) begin
                    en_a = 1'b0;
                end else if (rises == at_rise && act == 2) begin
                    rst_b = 1'b0;
                    #1;
                    check_val("rst_cs_high", int'(cs_b), 1);
                    check_val("rst_sclk_high", int'(sclk_b), 1);
                end
            end
            prev = s;
            if ((inst == 0) ? val_a : val_b) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic do_frame_a(input string tag, input logic [15:0] word, input int act,
                              input int exp_smp, input int exp_err);
        int n, lat, rises, per;
        word_a = word;
        wait_fall(0, 3000, n);
        check_val({tag, "_fall_period"}, (n < 0) ? -1 : cyc - last_fall, 2500);
        last_fall = cyc;
        run_frame(0, act, 8, lat, rises, per);
        check_val({tag, "_latency"}, lat, 66);
        check_val({tag, "_rises"}, rises, 16);
        check_val({tag, "_sclk_period"}, per, 4);
        check_val({tag, "_sample"}, int'(smp_a), exp_smp);
        check_val({tag, "_err"}, int'(err_a), exp_err);
        check_val({tag, "_cs_high"}, int'(cs_a), 1);
        @(negedge clk);
        check_val({tag, "_valid_pulse"}, int'(val_a), 0);
        check_val({tag, "_err_pulse"}, int'(err_a), 0);
        check_val({tag, "_sample_hold"}, int'(smp_a), exp_smp);
    endtask

    initial begin
        int n, lat, rises, per;

        // Reset defaults with enable already high.
        en_a = 1'b1;
        repeat (5) @(negedge clk);
        check_val("rst_cs_n", int'(cs_a), 1);
        check_val("rst_sclk", int'(sclk_a), 1);
        check_val("rst_sample", int'(smp_a), 0);
        check_val("rst_valid", int'(val_a), 0);
        check_val("rst_err", int'(err_a), 0);

        rst_a = 1'b1;
        last_fall = cyc;
        do_frame_a("nominal", 16'h0A5C, 0, 12'hA5C, 0);
        do_frame_a("ferr", 16'h8FFF, 0, 12'hFFF, 1);
        do_frame_a("max", 16'h0FFF, 0, 12'hFFF, 0);
        do_frame_a("zero", 16'h0000, 0, 12'h000, 0);
        do_frame_a("one", 16'h0001, 0, 12'h001, 0);

        // Enable drops at the 8th rise: frame completes, then bus stays quiet.
        do_frame_a("en_drop", 16'h0123, 1, 12'h123, 0);
        wait_fall(0, 3000, n);
        check_val("no_cs_while_disabled", n, -1);
        check_val("sclk_idle_disabled", int'(sclk_a), 1);
        en_a = 1'b1;
        last_fall = cyc;
        do_frame_a("reenable", 16'h07E1, 0, 12'h7E1, 0);

        // Fast variant: reset pulsed at the 5th rise of the first frame.
        word_b = 16'h0555;
        en_b   = 1'b1;
        @(negedge clk);
        rst_b  = 1'b1;
        wait_fall(1, 100, n);
        check_val("b_first_fall", n, 40);
        run_frame(1, 2, 5, lat, rises, per);
        check_val("b_rst_no_valid", lat, -1);
        check_val("b_rst_rises", rises, 5);
        check_val("b_rst_sample", int'(smp_b), 0);
        check_val("b_rst_cs_held", int'(cs_b), 1);

        word_b = 16'h0ABC;
        rst_b  = 1'b1;
        wait_fall(1, 100, n);
        check_val("b_fall_after_rst", n, 40);
        run_frame(1, 0, 0, lat, rises, per);
        check_val("b_latency", lat, 33);
        check_val("b_rises", rises, 16);
        check_val("b_sclk_period", per, 2);
        check_val("b_sample", int'(smp_b), 12'hABC);
        check_val("b_err", int'(err_b), 0);
        check_val("b_cs_high", int'(cs_b), 1);
        @(negedge clk);
        check_val("b_valid_pulse", int'(val_b), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
